// File: rtl/axi_stream_insert_header_if.sv
// Bundles the input stream, output stream and header-insert channels of
// axi_stream_insert_header; slave is the block's view, master the environment's.
interface axi_stream_insert_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic                    ready_insert;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_in, valid_out, data_out, keep_out, last_out, ready_insert
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_in, valid_out, data_out, keep_out, last_out, ready_insert
    );
endinterface

// File: rtl/axi_stream_insert_header.sv
// Prepends a 1..DATA_BYTE_WD byte header to each AXI-Stream packet and
// re-packs the merged MSB-first byte stream into full output beats.
module axi_stream_insert_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic                         clk,
    input logic                         rst_n,
    axi_stream_insert_header_if.slave   s
);
    localparam int            TW       = BYTE_CNT_WD + 2;
    localparam logic [TW-1:0] LP_BYTES = TW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH} state_t;

    state_t                  r_state;
    logic [DATA_WD-1:0]      r_res;
    logic [TW-1:0]           r_rcnt;
    logic                    r_valid_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_last_out;

    logic                    w_out_free;
    logic                    w_in_fire;
    logic                    w_hdr_fire;
    logic [TW-1:0]           w_hdr_len;
    logic [TW-1:0]           w_keep_cnt;
    logic [TW-1:0]           w_total;
    logic [2*DATA_WD-1:0]    w_cat_shift;
    logic [DATA_WD-1:0]      w_merge;
    logic                    w_unused_keep_insert;

    function automatic logic [DATA_WD-1:0] f_low_bytes(input logic [TW-1:0] n);
        return ~({DATA_WD{1'b1}} << (8 * n));
    endfunction

    function automatic logic [DATA_WD-1:0] f_high_bytes(input logic [TW-1:0] n);
        return ~({DATA_WD{1'b1}} >> (8 * n));
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] f_lead_keep(input logic [TW-1:0] n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    // Header length comes from byte_insert_cnt; keep_insert carries no extra information.
    assign w_unused_keep_insert = &{1'b0, s.keep_insert};

    assign w_out_free     = !r_valid_out || s.ready_out;
    assign s.ready_in     = (r_state == ST_STREAM) && w_out_free;
    assign s.ready_insert = (r_state == ST_IDLE);
    assign w_in_fire      = s.valid_in && s.ready_in;
    assign w_hdr_fire     = s.valid_insert && s.ready_insert;

    assign w_hdr_len  = TW'(s.byte_insert_cnt) + TW'(1);
    assign w_keep_cnt = s.last_in ? TW'($countones(s.keep_in)) : LP_BYTES;
    assign w_total    = r_rcnt + w_keep_cnt;

    // Residual bytes sit right-aligned in r_res; the leading beat of
    // {residual, data_in} is a window shifted down by the residual length.
    assign w_cat_shift = {r_res, s.data_in} >> (8 * r_rcnt);
    assign w_merge     = w_cat_shift[DATA_WD-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_res       <= '0;
            r_rcnt      <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
        end else begin
            if (r_valid_out && s.ready_out) begin
                r_valid_out <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_hdr_fire) begin
                        r_res   <= s.data_insert & f_low_bytes(w_hdr_len);
                        r_rcnt  <= w_hdr_len;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_in_fire) begin
                        r_valid_out <= 1'b1;
                        if (!s.last_in) begin
                            r_data_out <= w_merge;
                            r_keep_out <= '1;
                            r_last_out <= 1'b0;
                            r_res      <= s.data_in & f_low_bytes(r_rcnt);
                        end else if (w_total <= LP_BYTES) begin
                            r_data_out <= w_merge & f_high_bytes(w_total);
                            r_keep_out <= f_lead_keep(w_total);
                            r_last_out <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            // Leftover bytes are the kept data_in bytes beyond this beat, right-aligned.
                            r_data_out <= w_merge;
                            r_keep_out <= '1;
                            r_last_out <= 1'b0;
                            r_res      <= (s.data_in >> (8 * (LP_BYTES - w_keep_cnt)))
                                          & f_low_bytes(w_total - LP_BYTES);
                            r_rcnt     <= w_total - LP_BYTES;
                            r_state    <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_out_free) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= r_res << (8 * (LP_BYTES - r_rcnt));
                        r_keep_out  <= f_lead_keep(r_rcnt);
                        r_last_out  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s.valid_out = r_valid_out;
    assign s.data_out  = r_data_out;
    assign s.keep_out  = r_keep_out;
    assign s.last_out  = r_last_out;
endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header: a byte-queue model of the
// merged stream is checked against every output handshake.
module tb_axi_stream_insert_header;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axi_stream_insert_header_if #(.DATA_WD(32)) bus ();

    axi_stream_insert_header #(.DATA_WD(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  pend[$];
    beat_t       exp_q[$];
    beat_t       log_q[$];
    logic        held = 1'b0;
    beat_t       held_b;
    int          m_h;
    int          m_k;
    beat_t       m_got;
    beat_t       m_exp;
    logic [31:0] m_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic emit(input int n, input logic l);
        beat_t bt;
        bt.d = '0;
        bt.k = '0;
        for (int i = 0; i < n; i++) begin
            bt.d[31-8*i -: 8] = pend.pop_front();
            bt.k[3-i] = 1'b1;
        end
        bt.l = l;
        exp_q.push_back(bt);
    endtask

    // Model: packet = header bytes then kept data bytes, cut into 4-byte beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(bus.valid_out), 32'd1);
                check("hold_data", bus.data_out, held_b.d);
                check("hold_keep", 32'(bus.keep_out), 32'(held_b.k));
                check("hold_last", 32'(bus.last_out), 32'(held_b.l));
            end
            if (bus.valid_insert && bus.ready_insert) begin
                pend.delete();
                m_h = int'(bus.byte_insert_cnt) + 1;
                for (int b = m_h - 1; b >= 0; b--) pend.push_back(bus.data_insert[8*b +: 8]);
            end
            if (bus.valid_in && bus.ready_in) begin
                m_k = bus.last_in ? $countones(bus.keep_in) : 4;
                for (int b = 3; b >= 4 - m_k; b--) pend.push_back(bus.data_in[8*b +: 8]);
                while (pend.size() > 4) emit(4, 1'b0);
                if (bus.last_in) emit(pend.size(), 1'b1);
            end
            if (bus.valid_out && bus.ready_out) begin
                m_got.d = bus.data_out;
                m_got.k = bus.keep_out;
                m_got.l = bus.last_out;
                log_q.push_back(m_got);
                check("out_expected_present", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    m_exp = exp_q.pop_front();
                    m_mask = '0;
                    for (int i = 0; i < 4; i++) if (bus.keep_out[3-i]) m_mask[31-8*i -: 8] = 8'hFF;
                    check("out_data", bus.data_out & m_mask, m_exp.d);
                    check("out_keep", 32'(bus.keep_out), 32'(m_exp.k));
                    check("out_last", 32'(bus.last_out), 32'(m_exp.l));
                end
            end
            held = bus.valid_out && !bus.ready_out;
            held_b.d = bus.data_out;
            held_b.k = bus.keep_out;
            held_b.l = bus.last_out;
        end
    end

    task automatic send_header(input logic [31:0] d, input logic [3:0] k, input logic [1:0] cnt);
        int n = 0;
        logic hs = 1'b0;
        bus.valid_insert = 1'b1;
        bus.data_insert = d;
        bus.keep_insert = k;
        bus.byte_insert_cnt = cnt;
        do begin
            @(negedge clk);
            hs = bus.ready_insert;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        bus.valid_insert = 1'b0;
        check("header_handshake", 32'(hs), 32'd1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        logic hs = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in = d;
        bus.keep_in = k;
        bus.last_in = l;
        do begin
            @(negedge clk);
            hs = bus.ready_in;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        check("beat_handshake", 32'(hs), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        bus.valid_in = 1'b0;
        while ((exp_q.size() != 0 || bus.valid_out) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(exp_q.size() == 0 && !bus.valid_out), 32'd1);
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
        logic [31:0] m;
        check({name, "_present"}, 32'(idx < log_q.size()), 32'd1);
        if (idx < log_q.size()) begin
            m = '0;
            for (int i = 0; i < 4; i++) if (log_q[idx].k[3-i]) m[31-8*i -: 8] = 8'hFF;
            check({name, "_data"}, log_q[idx].d & m, d);
            check({name, "_keep"}, 32'(log_q[idx].k), 32'(k));
            check({name, "_last"}, 32'(log_q[idx].l), 32'(l));
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in = '0;
        bus.keep_in = '0;
        bus.last_in = 1'b0;
        bus.ready_out = 1'b1;
        bus.valid_insert = 1'b0;
        bus.data_insert = '0;
        bus.keep_insert = '0;
        bus.byte_insert_cnt = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_keep_out", 32'(bus.keep_out), 32'd0);
        check("rst_last_out", 32'(bus.last_out), 32'd0);
        check("rst_ready_in", 32'(bus.ready_in), 32'd0);
        check("rst_ready_insert", 32'(bus.ready_insert), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: H=3, data held valid before the header arrives
        log_q.delete();
        bus.valid_in = 1'b1;
        bus.data_in = 32'h01020304;
        bus.keep_in = 4'hF;
        bus.last_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t1_ready_in_before_hdr", 32'(bus.ready_in), 32'd0);
        end
        @(posedge clk);
        #1;
        send_header(32'hAA55AA55, 4'b0111, 2'd2);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        send_beat(32'h090A0B0C, 4'hF, 1'b1);
        drain();
        check("t1_beats", 32'(log_q.size()), 32'd4);
        chk_beat("t1_b0", 0, 32'h55AA5501, 4'hF, 1'b0);
        chk_beat("t1_b1", 1, 32'h02030405, 4'hF, 1'b0);
        chk_beat("t1_b3", 3, 32'h0A0B0C00, 4'b1110, 1'b1);

        // Test 2: downstream stall mid-packet
        log_q.delete();
        fork
            begin
                send_header(32'h0000BEEF, 4'b0011, 2'd1);
                send_beat(32'h10111213, 4'hF, 1'b0);
                send_beat(32'h14151617, 4'hF, 1'b0);
                send_beat(32'h18191A1B, 4'hF, 1'b0);
                send_beat(32'h1C1D1E1F, 4'hF, 1'b1);
                bus.valid_in = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.ready_out = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.valid_out) check("t2_ready_in_stall", 32'(bus.ready_in), 32'd0);
                end
                @(posedge clk);
                #1;
                bus.ready_out = 1'b1;
            end
        join
        drain();
        check("t2_beats", 32'(log_q.size()), 32'd5);
        chk_beat("t2_b0", 0, 32'hBEEF1011, 4'hF, 1'b0);
        chk_beat("t2_b4", 4, 32'h1E1F0000, 4'b1100, 1'b1);

        // Test 3: T=5 on the last beat forces a flush beat
        log_q.delete();
        send_header(32'h00C0C1C2, 4'b0111, 2'd2);
        send_beat(32'hD0D1D2D3, 4'hF, 1'b0);
        send_beat(32'hE0E1FFFF, 4'b1100, 1'b1);
        bus.valid_in = 1'b0;
        @(negedge clk);
        check("t3_ready_in_flush", 32'(bus.ready_in), 32'd0);
        drain();
        check("t3_beats", 32'(log_q.size()), 32'd3);
        chk_beat("t3_b1", 1, 32'hD1D2D3E0, 4'hF, 1'b0);
        chk_beat("t3_b2", 2, 32'hE1000000, 4'b1000, 1'b1);

        // Test 4: single-byte header, short last beat fits in one output beat
        log_q.delete();
        send_header(32'hAA55AA66, 4'b0001, 2'd0);
        send_beat(32'h77889999, 4'b1100, 1'b1);
        drain();
        check("t4_beats", 32'(log_q.size()), 32'd1);
        chk_beat("t4_b0", 0, 32'h66778800, 4'b1110, 1'b1);

        // Test 5: full-width header, second header refused, input gaps
        log_q.delete();
        send_header(32'hAA55AA77, 4'hF, 2'd3);
        bus.valid_insert = 1'b1;
        bus.data_insert = 32'hAA55AA88;
        @(negedge clk);
        check("t5_second_hdr_blocked", 32'(bus.ready_insert), 32'd0);
        @(posedge clk);
        #1;
        bus.valid_insert = 1'b0;
        send_beat(32'h01020304, 4'hF, 1'b0);
        bus.valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_beat(32'h05060708, 4'hF, 1'b0);
        send_beat(32'h090A0000, 4'b1100, 1'b1);
        drain();
        check("t5_beats", 32'(log_q.size()), 32'd4);
        chk_beat("t5_b0", 0, 32'hAA55AA77, 4'hF, 1'b0);
        chk_beat("t5_b1", 1, 32'h01020304, 4'hF, 1'b0);
        chk_beat("t5_b3", 3, 32'h090A0000, 4'b1100, 1'b1);

        // Test 6: reset mid-packet, then a clean packet
        send_header(32'h00000012, 4'b0001, 2'd0);
        send_beat(32'h3456789A, 4'hF, 1'b0);
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("t6_rst_data_out", bus.data_out, 32'd0);
        check("t6_rst_keep_out", 32'(bus.keep_out), 32'd0);
        check("t6_rst_last_out", 32'(bus.last_out), 32'd0);
        check("t6_rst_ready_in", 32'(bus.ready_in), 32'd0);
        check("t6_rst_ready_insert", 32'(bus.ready_insert), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_q.delete();
        send_header(32'h00000012, 4'b0001, 2'd0);
        send_beat(32'h3456789A, 4'hF, 1'b1);
        drain();
        check("t6_beats", 32'(log_q.size()), 32'd2);
        chk_beat("t6_b0", 0, 32'h12345678, 4'hF, 1'b0);
        chk_beat("t6_b1", 1, 32'h9A000000, 4'b1000, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("end_exp_empty", 32'(exp_q.size()), 32'd0);
        check("end_pend_empty", 32'(pend.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_stream_insert_header.md
Name: axi_stream_insert_header

Overview:
- Prepends a variable-length header (1..DATA_BYTE_WD bytes) to each AXI-Stream packet.
- The header is taken from a separate insert channel; the merged byte stream is re-packed into full output beats.
- Sits inline between a packet source and sink; byte order is MSB-first within a beat.
- Only the final output beat of a packet may be partial.

Parameters:
- DATA_WD, 32, data bus width in bits.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  input data valid.
- data_in  in  DATA_WD  input data; byte DATA_BYTE_WD-1 (MSB) is first.
- keep_in  in  DATA_BYTE_WD  byte enables, left-aligned contiguous ones; all ones except possibly on last beat.
- last_in  in  1  last input beat of packet.
- ready_in  out  1  input ready.
- valid_out  out  1  output valid.
- data_out  out  DATA_WD  output data.
- keep_out  out  DATA_BYTE_WD  output byte enables, left-aligned.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream ready.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header; valid bytes are the low bytes.
- keep_insert  in  DATA_BYTE_WD  header enables, right-aligned contiguous ones.
- byte_insert_cnt  in  BYTE_CNT_WD  header valid bytes minus 1 (H = cnt+1).
- ready_insert  out  1  header ready.

Behaviour:
- Reset: valid_out, data_out, keep_out, last_out, ready_in = 0; residual buffer cleared; state IDLE.
- Handshakes occur when valid and ready are both high at a rising edge.
- valid_out/data_out/keep_out/last_out must stay stable while valid_out=1 and ready_out=0.
- IDLE state:
  - ready_insert=1, ready_in=0.
  - On header handshake: load the low H bytes of data_insert into the residual buffer (count R=H); go to STREAM.
  - ready_insert deasserts the cycle after acceptance, so only one header is taken per packet.
- STREAM state:
  - ready_insert=0; ready_in = !valid_out || ready_out.
  - Non-last input beat: output register loads the top DATA_BYTE_WD bytes of {residual[R bytes], data_in[4 bytes]} with keep all ones and last_out=0.
  - The low R bytes of data_in become the new residual; R stays H.
  - Latency is one cycle from input handshake to valid_out.
- Last input beat with K = popcount(keep_in) valid bytes; total T = R+K:
  - T ≤ DATA_BYTE_WD: emit one beat containing the T bytes, keep_out = T leading ones, last_out=1; go to IDLE.
  - T > DATA_BYTE_WD: emit a full beat (last_out=0), keep the remaining T-DATA_BYTE_WD bytes, go to FLUSH.
- FLUSH state:
  - ready_in=0, ready_insert=0.
  - When the output register is free, emit the remaining bytes left-aligned with matching keep and last_out=1; go to IDLE.
- H = DATA_BYTE_WD: the first output beat is the header alone; the mechanism is otherwise unchanged.
- A new header may be accepted in IDLE while the previous last beat is still held in the output register.
- Back-to-back packets have no bubbles other than the header wait.
- The emitted byte stream for each packet must equal the header bytes followed by all kept input bytes.
- keep_in on non-last beats is treated as all ones.
- Asserting rst_n low mid-packet aborts the packet immediately; no partial beat is emitted after reset.

Test Plan:
- Header AA55AA55 with keep 0111 and cnt 2, data 01020304 incrementing by 04040404 each beat -> ready_in stays 0 until the header is accepted. Outputs are 55AA5501, 02030405, and so on.
- ready_out held low for 4 cycles mid-packet -> data_out holds stable, ready_in=0, no bytes lost or duplicated.
- Last input beat with keep 1100 after header H=3 -> T=5. Output is a full beat, then a flush beat with keep 1000 and last_out=1. ready_in=0 during the flush.
- Header AA55AA66 with keep 0001 and cnt 0; last input keep 1100 -> T=3. A single last beat with keep 1110 is emitted.
- Header with keep 1111 and cnt 3, data AA55AA77 then AA55AA88 presented on consecutive cycles -> only AA55AA77 is accepted. The first output beat is AA55AA77 and the last beat carries the 2 leftover data bytes. valid_in low for 4 cycles causes no output gap corruption.
- Assert rst_n low mid-packet -> all outputs 0 and ready_insert=1. The next packet starts cleanly with a new header.
